// File: rtl/dc_sweep_sequencer_if.sv
// dc_sweep_sequencer_if: control, DAC, ADC and result-stream signals of the sweep sequencer; master = environment, slave = sequencer
interface dc_sweep_sequencer_if #(
  parameter int DAC_W = 8,
  parameter int ADC_W = 10
);
  logic             start;
  logic             abort;
  logic [DAC_W-1:0] start_code;
  logic [DAC_W-1:0] stop_code;
  logic [DAC_W-1:0] step_code;
  logic [DAC_W-1:0] dac_code;
  logic             dac_load;
  logic             adc_req;
  logic             adc_ack;
  logic [ADC_W-1:0] adc_data;
  logic             res_valid;
  logic             res_ready;
  logic [DAC_W-1:0] res_code;
  logic [ADC_W-1:0] res_data;
  logic             busy;
  logic             done;
  modport master (
    output start, abort, start_code, stop_code, step_code, adc_ack, adc_data, res_ready,
    input  dac_code, dac_load, adc_req, res_valid, res_code, res_data, busy, done
  );
  modport slave (
    input  start, abort, start_code, stop_code, step_code, adc_ack, adc_data, res_ready,
    output dac_code, dac_load, adc_req, res_valid, res_code, res_data, busy, done
  );
endinterface

// File: rtl/dc_sweep_sequencer.sv
// dc_sweep_sequencer: steps a DAC code start..stop, settles, requests an ADC conversion and streams (code,result); ports clk, rst, bus (dc_sweep_sequencer_if.slave)
module dc_sweep_sequencer #(
  parameter int DAC_W = 8,
  parameter int ADC_W = 10,
  parameter int SETTLE_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  dc_sweep_sequencer_if.slave bus
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, EMIT, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [DAC_W-1:0] cur_q, cur_d, stop_q, stop_d, step_q, step_d, dac_q, dac_d, rcode_q, rcode_d;
  logic [ADC_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DAC_W:0] sum;
  assign sum = {1'b0, cur_q} + {1'b0, step_q};
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    stop_d = stop_q;
    step_d = step_q;
    dac_d = dac_q;
    rcode_d = rcode_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        cur_d = bus.start_code;
        dac_d = bus.start_code;
        stop_d = bus.stop_code;
        step_d = bus.step_code;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d = CW'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? SAMPLE : SETTLE;
      end
      SAMPLE: if (bus.adc_ack) begin
        rcode_d = cur_q;
        rdata_d = bus.adc_data;
        state_d = EMIT;
      end
      EMIT: state_d = bus.res_ready ? NEXT : EMIT;
      NEXT: if (step_q == '0 || sum > {1'b0, stop_q}) state_d = DONE;
      else begin
        cur_d = sum[DAC_W-1:0];
        dac_d = sum[DAC_W-1:0];
        state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      dac_d = dac_q;
      cur_d = cur_q;
      stop_d = stop_q;
      step_d = step_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q <= '0;
      stop_q <= '0;
      step_q <= '0;
      dac_q <= '0;
      rcode_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      stop_q <= stop_d;
      step_q <= step_d;
      dac_q <= dac_d;
      rcode_q <= rcode_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.dac_code = dac_q;
  assign bus.dac_load = state_q == LOAD;
  assign bus.adc_req = state_q == SAMPLE;
  assign bus.res_valid = state_q == EMIT;
  assign bus.res_code = rcode_q;
  assign bus.res_data = rdata_q;
  assign bus.busy = !(state_q == IDLE || state_q == DONE);
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// tb_dc_sweep_sequencer: table-driven and randomized sweeps checked against a point-list model of the sweep rules
module tb_dc_sweep_sequencer;
  logic clk = 0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  dc_sweep_sequencer_if #(.DAC_W(8), .ADC_W(10)) bus ();
  dc_sweep_sequencer #(.DAC_W(8), .ADC_W(10), .SETTLE_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic [7:0] s;
    logic [7:0] p;
    logic [7:0] t;
    int ack_dly;
    int stall_pt;
    int stall_len;
    int abort_pt;
    int spur;
    int exp_n;
    int exp_last;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_dac_code"}, bus.dac_code, 0);
    chk({tag, "_dac_load"}, bus.dac_load, 0);
    chk({tag, "_adc_req"}, bus.adc_req, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_code"}, bus.res_code, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask
  task automatic sweep(input vec_t v);
    logic [7:0] exp_c[$];
    logic [9:0] exp_d[$];
    int c, cyc, loads, dones, got, reqc, stall, first_req;
    bit fin, ab;
    c = int'(v.s);
    forever begin
      exp_c.push_back(8'(c));
      if (v.t == 0 || c + int'(v.t) > int'(v.p)) break;
      c += int'(v.t);
    end
    @(negedge clk);
    bus.start = 1;
    bus.start_code = v.s;
    bus.stop_code = v.p;
    bus.step_code = v.t;
    cyc = 0; loads = 0; dones = 0; got = 0; reqc = 0; stall = 0; first_req = -1; fin = 0; ab = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      bus.start = v.spur != 0 && cyc == v.spur;
      bus.start_code = 8'($urandom);
      bus.stop_code = 8'($urandom);
      bus.step_code = 8'($urandom);
      if (cyc == 1) begin
        chk("load_at_cycle1", bus.dac_load, 1);
        chk("busy_at_cycle1", bus.busy, 1);
      end
      if (ab) begin
        chk("abort_req", bus.adc_req, 0);
        chk("abort_valid", bus.res_valid, 0);
        chk("abort_load", bus.dac_load, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        bus.abort = 0;
        break;
      end
      if (fin) begin
        chk("done_width", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        break;
      end
      if (bus.dac_load) begin
        loads++;
        chk("load_code", bus.dac_code, loads <= exp_c.size() ? int'(exp_c[loads-1]) : -1);
        chk("load_after_handshake", got, loads - 1);
      end
      if (bus.adc_req && first_req < 0) first_req = cyc;
      reqc = bus.adc_req ? reqc + 1 : 0;
      if (bus.adc_req && v.abort_pt == loads - 1 && reqc == 2) begin
        bus.abort = 1;
        ab = 1;
      end
      bus.adc_ack = bus.adc_req && !ab && reqc == v.ack_dly + 1;
      bus.adc_data = 10'($urandom);
      if (bus.adc_ack) exp_d.push_back(bus.adc_data);
      bus.res_ready = !(bus.res_valid && got == v.stall_pt && stall < v.stall_len);
      if (bus.res_valid && !bus.res_ready) begin
        stall++;
        chk("stall_code", bus.res_code, got < exp_c.size() ? int'(exp_c[got]) : -1);
        chk("stall_data", bus.res_data, got < exp_d.size() ? int'(exp_d[got]) : -1);
      end
      if (bus.res_valid && bus.res_ready) begin
        chk("res_code", bus.res_code, got < exp_c.size() ? int'(exp_c[got]) : -1);
        chk("res_data", bus.res_data, got < exp_d.size() ? int'(exp_d[got]) : -1);
        got++;
      end
      if (bus.done) begin
        dones++;
        fin = 1;
        chk("done_busy", bus.busy, 0);
      end
      if (cyc > 4000) begin
        chk("timeout", cyc, 0);
        break;
      end
    end
    bus.start = 0;
    bus.abort = 0;
    bus.adc_ack = 0;
    bus.res_ready = 1;
    chk("first_req_cycle", first_req, 18);
    chk("results", got, v.exp_n < 0 ? exp_c.size() : v.exp_n);
    chk("loads", loads, v.abort_pt < 0 ? exp_c.size() : v.abort_pt + 1);
    chk("done_pulses", dones, v.abort_pt < 0 ? 1 : 0);
    chk("final_dac_code", bus.dac_code, v.exp_last < 0 ? int'(exp_c[exp_c.size()-1]) : v.exp_last);
    @(negedge clk);
  endtask
  initial begin
    vec_t v;
    rst = 1;
    bus.start = 0;
    bus.abort = 0;
    bus.start_code = 0;
    bus.stop_code = 0;
    bus.step_code = 0;
    bus.adc_ack = 0;
    bus.adc_data = 0;
    bus.res_ready = 1;
    tbl.push_back('{8'd10, 8'd40, 8'd10, 3, -1, 0, -1, 0, 4, 40});
    tbl.push_back('{8'd10, 8'd40, 8'd10, 3, 1, 5, -1, 0, 4, 40});
    tbl.push_back('{8'd250, 8'd255, 8'd10, 2, -1, 0, -1, 0, 1, 250});
    tbl.push_back('{8'd5, 8'd100, 8'd0, 1, 0, 2, -1, 0, 1, 5});
    tbl.push_back('{8'd7, 8'd3, 8'd5, 0, -1, 0, -1, 0, 1, 7});
    tbl.push_back('{8'd10, 8'd40, 8'd10, 3, -1, 0, 1, 0, 1, 20});
    tbl.push_back('{8'd10, 8'd40, 8'd10, 3, -1, 0, -1, 5, 4, 40});
    tbl.push_back('{8'd0, 8'd255, 8'd85, 4, 3, 3, -1, 0, 4, 255});
    tbl.push_back('{8'd0, 8'd0, 8'd1, 0, -1, 0, -1, 0, 1, 0});
    tbl.push_back('{8'd200, 8'd255, 8'd55, 1, 0, 1, -1, 0, 2, 255});
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst = 0;
    foreach (tbl[i]) sweep(tbl[i]);
    bus.start = 1;
    bus.start_code = 8'd30;
    bus.stop_code = 8'd90;
    bus.step_code = 8'd30;
    @(negedge clk);
    bus.start = 0;
    repeat (4) @(negedge clk);
    chk("settle_busy", bus.busy, 1);
    chk("settle_dac_code", bus.dac_code, 30);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_rst("mid_rst");
    for (int k = 0; k < 8; k++) begin
      v.s = 8'($urandom_range(0, 255));
      v.p = 8'($urandom_range(0, 255));
      v.t = 8'($urandom_range(15, 120));
      v.ack_dly = $urandom_range(0, 4);
      v.stall_pt = $urandom_range(0, 3);
      v.stall_len = $urandom_range(0, 4);
      v.abort_pt = -1;
      v.spur = (k % 2 == 1) ? 7 : 0;
      v.exp_n = -1;
      v.exp_last = -1;
      sweep(v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dc_sweep_sequencer.md
Name: dc_sweep_sequencer

Overview:
Digital stimulus/measurement sequencer that sits directly upstream of the analog test circuit's source V1 and downstream of its output node. It steps a DAC code from a start value to a stop value and waits a fixed settle time at each point. It then requests an ADC conversion of the "out" node and emits each (code, result) pair on a valid/ready stream for the checker. This replaces a hand-run DC sweep of the short_circuit test bench with a cycle-exact sequenced sweep.

Parameters:
DAC_W, 8, width of DAC code (source setpoint).
ADC_W, 10, width of ADC conversion result.
SETTLE_CYCLES, 16, cycles waited after each DAC load before sampling (>=1).

Ports:
clk  input  1  single clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a sweep when idle.
abort  input  1  terminates sweep; priority over everything except rst.
start_code  input  DAC_W  first sweep point, sampled on accepted start.
stop_code  input  DAC_W  last allowed sweep point, sampled on accepted start.
step_code  input  DAC_W  increment, sampled on accepted start.
dac_code  output  DAC_W  setpoint driven to source.
dac_load  output  1  one-cycle strobe when dac_code changes.
adc_req  output  1  conversion request, level, held until ack.
adc_ack  input  1  conversion complete; adc_data valid same cycle.
adc_data  input  ADC_W  conversion result.
res_valid  output  1  result stream valid.
res_ready  input  1  result stream ready.
res_code  output  DAC_W  DAC code of this result.
res_data  output  ADC_W  ADC result.
busy  output  1  high in any state except IDLE/DONE.
done  output  1  one-cycle pulse on sweep completion (not on abort).

Behaviour:
- Reset: state IDLE; dac_code=0, dac_load=0, adc_req=0, res_valid=0, res_code=0, res_data=0, busy=0, done=0; internal registers cleared. rst mid-sweep discards everything.
- States: IDLE, LOAD, SETTLE, SAMPLE, EMIT, NEXT, DONE.
- IDLE: start=1 latches start/stop/step codes, goes to LOAD. start while busy is ignored.
- LOAD (1 cycle): dac_code<=current code, dac_load=1 this cycle; settle counter<=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: counter decrements each cycle; at 0 go to SAMPLE. Exactly SETTLE_CYCLES cycles are spent in SETTLE.
- SAMPLE: adc_req=1 from the first SAMPLE cycle until the cycle adc_ack=1 (inclusive). On ack, capture adc_data into res_data and current code into res_code, deassert adc_req next cycle, go to EMIT. adc_ack outside SAMPLE is ignored.
- EMIT: res_valid=1; res_code and res_data held stable until res_valid&res_ready. On handshake go to NEXT; res_valid drops next cycle.
- NEXT: sum = current+step, computed at DAC_W+1 bits. If step==0, or sum>stop_code, or sum overflows DAC_W, go to DONE. Else current<=sum and go to LOAD.
- stop_code<start_code: exactly one point (start_code) is measured, then DONE.
- DONE (1 cycle): done=1, then IDLE. dac_code retains last value.
- abort in any busy state: next state IDLE; adc_req, res_valid, dac_load forced 0 next cycle; done not pulsed; dac_code retained. Pending result is dropped.
- Latency, start pulse at cycle 0: LOAD at cycle 1 (dac_load high), SETTLE cycles 2..1+SETTLE_CYCLES, adc_req first high at cycle 2+SETTLE_CYCLES.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.

Test Plan:
1. Reset then start with start=10, stop=40, step=10, SETTLE=16, ack 3 cycles after req, ready always 1 -> four results, codes 10,20,30,40; dac_load pulses at 4 points; done one pulse; first adc_req at cycle 18.
2. Same sweep with res_ready low 5 cycles on the second result -> res_code=20 and res_data held stable, no new dac_load until handshake.
3. start=250, stop=255, step=10 -> single result code 250 (sum 260 overflows), then done.
4. step=0, start=5, stop=100 -> single result code 5, done; stop=3, start=7 -> single result code 7.
5. abort asserted while adc_req high on the second point -> adc_req low next cycle, IDLE, no done, no res_valid; dac_code stays at the second code. A new start then runs normally.
6. rst asserted during SETTLE -> all outputs to reset values next cycle; start pulse while busy is ignored, with latched codes unchanged.
